// File: rtl/lamp_sequence_monitor.sv
// Receive-side checker for the one-hot traffic-lamp code bus: checks the
// green -> yellow -> red order and per-phase dwell, and counts completed cycles.
module lamp_sequence_monitor #(
   parameter int unsigned MIN_DWELL = 1,
   parameter int unsigned MAX_DWELL = 1,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       light,
   input  logic             clr,
   output logic             in_sync,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

   localparam logic [1:0] PH_NONE   = 2'b00;
   localparam logic [1:0] PH_GREEN  = 2'b01;
   localparam logic [1:0] PH_YELLOW = 2'b10;
   localparam logic [1:0] PH_RED    = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_ORDER   = 2'b10;
   localparam logic [1:0] ERR_DWELL   = 2'b11;

   localparam logic [CNT_W-1:0] DW_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] DW_MIN = CNT_W'(MIN_DWELL);
   localparam logic [CNT_W-1:0] DW_MAX = CNT_W'(MAX_DWELL);
   localparam logic [CNT_W-1:0] SAT    = '1;

   state_t           state;
   logic [CNT_W-1:0] dwell;
   logic             first;

   logic [1:0] light_ph;
   logic [1:0] succ;
   logic       legal;
   logic       fault;
   logic [1:0] fault_code;
   logic       accept;

   // Decode the lamp code and the legal successor of the current phase
   always_comb begin
      light_ph = PH_NONE;
      unique case (light)
         3'b010:  light_ph = PH_GREEN;
         3'b001:  light_ph = PH_YELLOW;
         3'b100:  light_ph = PH_RED;
         default: light_ph = PH_NONE;
      endcase
      legal = (light_ph != PH_NONE);

      succ = PH_NONE;
      unique case (phase)
         PH_GREEN:  succ = PH_YELLOW;
         PH_YELLOW: succ = PH_RED;
         PH_RED:    succ = PH_GREEN;
         default:   succ = PH_NONE;
      endcase
   end

   // Tracking verdict; checks ordered so illegal beats bad order beats dwell
   always_comb begin
      fault      = 1'b0;
      fault_code = ERR_NONE;
      accept     = 1'b0;
      if (!legal) begin
         fault      = 1'b1;
         fault_code = ERR_ILLEGAL;
      end else if (light_ph == phase) begin
         if (dwell == DW_MAX) begin
            fault      = 1'b1;
            fault_code = ERR_DWELL;
         end
      end else if (light_ph != succ) begin
         fault      = 1'b1;
         fault_code = ERR_ORDER;
      end else if (!first && (dwell < DW_MIN)) begin
         // The phase seen at lock may have started before we looked
         fault      = 1'b1;
         fault_code = ERR_DWELL;
      end else begin
         accept = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SYNC;
         in_sync   <= 1'b0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
         phase     <= PH_NONE;
         cycle_cnt <= '0;
         dwell     <= '0;
         first     <= 1'b0;
      end else if (clr) begin
         state    <= SYNC;
         in_sync  <= 1'b0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
         phase    <= PH_NONE;
         dwell    <= '0;
         first    <= 1'b0;
      end else begin
         unique case (state)
            SYNC: begin
               if (legal) begin
                  state   <= TRACK;
                  in_sync <= 1'b1;
                  phase   <= light_ph;
                  dwell   <= DW_ONE;
                  first   <= 1'b1;
               end
            end
            TRACK: begin
               if (fault) begin
                  state    <= FAULT;
                  in_sync  <= 1'b0;
                  err      <= 1'b1;
                  err_code <= fault_code;
               end else if (accept) begin
                  phase <= light_ph;
                  dwell <= DW_ONE;
                  first <= 1'b0;
                  if ((phase == PH_RED) && (cycle_cnt != SAT))
                     cycle_cnt <= cycle_cnt + CNT_W'(1);
               end else if (dwell != SAT) begin
                  dwell <= dwell + CNT_W'(1);
               end
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state <= SYNC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Directed bench for lamp_sequence_monitor: three parameterisations, expected
// outputs queued when each step is driven and checked after the clock edge.
module tb_lamp_sequence_monitor;

   typedef struct packed {
      logic       in_sync;
      logic       err;
      logic [1:0] err_code;
      logic [1:0] phase;
      logic [7:0] cycle_cnt;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0 = 1'b1, clr0 = 1'b0;
   logic [2:0] light0 = 3'b000;
   logic       in_sync0, err0;
   logic [1:0] err_code0, phase0;
   logic [7:0] cycle_cnt0;

   logic       rst1 = 1'b1, clr1 = 1'b0;
   logic [2:0] light1 = 3'b000;
   logic       in_sync1, err1;
   logic [1:0] err_code1, phase1;
   logic [7:0] cycle_cnt1;

   logic       rst2 = 1'b1, clr2 = 1'b0;
   logic [2:0] light2 = 3'b000;
   logic       in_sync2, err2;
   logic [1:0] err_code2, phase2;
   logic [1:0] cycle_cnt2;

   lamp_sequence_monitor u_def (
      .clk(clk), .rst(rst0), .light(light0), .clr(clr0),
      .in_sync(in_sync0), .err(err0), .err_code(err_code0),
      .phase(phase0), .cycle_cnt(cycle_cnt0));

   lamp_sequence_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .CNT_W(8)) u_dw (
      .clk(clk), .rst(rst1), .light(light1), .clr(clr1),
      .in_sync(in_sync1), .err(err1), .err_code(err_code1),
      .phase(phase1), .cycle_cnt(cycle_cnt1));

   lamp_sequence_monitor #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst2), .light(light2), .clr(clr2),
      .in_sync(in_sync2), .err(err2), .err_code(err_code2),
      .phase(phase2), .cycle_cnt(cycle_cnt2));

   obs_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad   = 0;

   localparam logic [2:0] G = 3'b010;
   localparam logic [2:0] Y = 3'b001;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Z = 3'b000;

   function automatic obs_t mk(input logic s, input logic e, input logic [1:0] ec,
                               input logic [1:0] ph, input int cc);
      obs_t o;
      o.in_sync   = s;
      o.err       = e;
      o.err_code  = ec;
      o.phase     = ph;
      o.cycle_cnt = 8'(cc);
      return o;
   endfunction

   function automatic logic [1:0] ph_of(input logic [2:0] l);
      case (l)
         G:       return 2'b01;
         Y:       return 2'b10;
         R:       return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   task automatic check(input int sel);
      obs_t  o, e;
      string tag;
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      case (sel)
         0:       o = {in_sync0, err0, err_code0, phase0, cycle_cnt0};
         1:       o = {in_sync1, err1, err_code1, phase1, cycle_cnt1};
         default: o = {in_sync2, err2, err_code2, phase2, 6'b0, cycle_cnt2};
      endcase
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: got sync=%0b err=%0b code=%0d phase=%0d cnt=%0d, exp sync=%0b err=%0b code=%0d phase=%0d cnt=%0d",
                tag, o.in_sync, o.err, o.err_code, o.phase, o.cycle_cnt,
                e.in_sync, e.err, e.err_code, e.phase, e.cycle_cnt);
      end
   endtask

   task automatic step(input int sel, input string tag, input logic r, input logic c,
                       input logic [2:0] l, input obs_t e);
      case (sel)
         0:       begin rst0 = r; clr0 = c; light0 = l; end
         1:       begin rst1 = r; clr1 = c; light1 = l; end
         default: begin rst2 = r; clr2 = c; light2 = l; end
      endcase
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      check(sel);
   endtask

   initial begin
      logic [2:0] rot [3];
      int         cc;
      rot[0] = Y; rot[1] = R; rot[2] = G;

      // Default parameters: lock after idle zeros, then two completed cycles
      step(0, "d0_reset", 1, 0, Z, mk(0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         step(0, "d0_idle_zero", 0, 0, Z, mk(0, 0, 0, 0, 0));
      step(0, "d0_lock_g", 0, 0, G, mk(1, 0, 0, 1, 0));
      step(0, "d0_y", 0, 0, Y, mk(1, 0, 0, 2, 0));
      step(0, "d0_r", 0, 0, R, mk(1, 0, 0, 3, 0));
      step(0, "d0_g1", 0, 0, G, mk(1, 0, 0, 1, 1));
      step(0, "d0_y2", 0, 0, Y, mk(1, 0, 0, 2, 1));
      step(0, "d0_r2", 0, 0, R, mk(1, 0, 0, 3, 1));
      step(0, "d0_g2", 0, 0, G, mk(1, 0, 0, 1, 2));
      // Green straight to red is out of order; first cause sticks
      step(0, "d0_bad_order", 0, 0, R, mk(0, 1, 2, 1, 2));
      step(0, "d0_sticky", 0, 0, 3'b110, mk(0, 1, 2, 1, 2));
      step(0, "d0_clr", 0, 1, G, mk(0, 0, 0, 0, 2));
      step(0, "d0_relock", 0, 0, G, mk(1, 0, 0, 1, 2));
      step(0, "d0_illegal", 0, 0, 3'b110, mk(0, 1, 1, 1, 2));
      step(0, "d0_clr2", 0, 1, Z, mk(0, 0, 0, 0, 2));
      step(0, "d0_relock2", 0, 0, G, mk(1, 0, 0, 1, 2));
      step(0, "d0_repeat_dwell", 0, 0, G, mk(0, 1, 3, 1, 2));
      step(0, "d0_rst_over_clr", 1, 1, G, mk(0, 0, 0, 0, 0));
      step(0, "d0_lock_after_rst", 0, 0, G, mk(1, 0, 0, 1, 0));
      step(0, "d0_y_pre_rst", 0, 0, Y, mk(1, 0, 0, 2, 0));
      step(0, "d0_mid_rst", 1, 0, Y, mk(0, 0, 0, 0, 0));
      step(0, "d0_lock_red", 0, 0, R, mk(1, 0, 0, 3, 0));
      step(0, "d0_red_green", 0, 0, G, mk(1, 0, 0, 1, 1));

      // MIN_DWELL=2, MAX_DWELL=3
      step(1, "d1_reset", 1, 0, Z, mk(0, 0, 0, 0, 0));
      step(1, "d1_g_a", 0, 0, G, mk(1, 0, 0, 1, 0));
      step(1, "d1_g_b", 0, 0, G, mk(1, 0, 0, 1, 0));
      step(1, "d1_y_a", 0, 0, Y, mk(1, 0, 0, 2, 0));
      step(1, "d1_y_b", 0, 0, Y, mk(1, 0, 0, 2, 0));
      step(1, "d1_r_a", 0, 0, R, mk(1, 0, 0, 3, 0));
      step(1, "d1_r_b", 0, 0, R, mk(1, 0, 0, 3, 0));
      step(1, "d1_g2_a", 0, 0, G, mk(1, 0, 0, 1, 1));
      step(1, "d1_g2_b", 0, 0, G, mk(1, 0, 0, 1, 1));
      for (int i = 0; i < 3; i++)
         step(1, "d1_y_hold", 0, 0, Y, mk(1, 0, 0, 2, 1));
      step(1, "d1_y_over_max", 0, 0, Y, mk(0, 1, 3, 2, 1));
      step(1, "d1_clr", 0, 1, Z, mk(0, 0, 0, 0, 1));
      // Leaving the lock phase early is allowed; a later short phase is not
      step(1, "d1_lock_r", 0, 0, R, mk(1, 0, 0, 3, 1));
      step(1, "d1_first_short_ok", 0, 0, G, mk(1, 0, 0, 1, 2));
      step(1, "d1_g_too_short", 0, 0, Y, mk(0, 1, 3, 1, 2));

      // CNT_W=2: cycle counter saturates at 3
      step(2, "d2_reset", 1, 0, Z, mk(0, 0, 0, 0, 0));
      step(2, "d2_lock_g", 0, 0, G, mk(1, 0, 0, 1, 0));
      cc = 0;
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 3; j++) begin
            if (rot[j] == G && cc < 3) cc++;
            step(2, "d2_rotate", 0, 0, rot[j], mk(1, 0, 0, ph_of(rot[j]), cc));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lamp_sequence_monitor.md
Name: lamp_sequence_monitor

Overview:
Receive-side checker for the 3-bit one-hot traffic-lamp code bus driven by the cyclic lamp generator. It samples the lamp code every clock and checks the legal order green -> yellow -> red -> green and the per-phase dwell time. It flags illegal codes, out-of-order transitions and dwell violations, and counts completed lamp cycles. Intended as an in-system watchdog beside the generator and as a reusable checker in benches.

Parameters:
MIN_DWELL, 1, minimum cycles a lamp code must be held before changing (>=1)
MAX_DWELL, 1, maximum cycles a lamp code may be held (>= MIN_DWELL)
CNT_W, 8, width of dwell counter and completed-cycle counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
light  input  3  lamp code: red=3'b100, green=3'b010, yellow=3'b001
clr  input  1  synchronous error clear / resynchronise, active-high
in_sync  output  1  monitor is locked to a legal sequence, no fault
err  output  1  sticky error flag
err_code  output  2  first error cause: 00 none, 01 illegal code, 10 bad order, 11 dwell violation
phase  output  2  current decoded phase: 00 none, 01 green, 10 yellow, 11 red
cycle_cnt  output  CNT_W  completed red->green transitions, saturating at all-ones

Behaviour:
- Reset (rst=1 at an edge): FSM=SYNC; in_sync=0, err=0, err_code=00, phase=00, cycle_cnt=0, dwell=0. rst has priority over clr.
- Decode: 100/010/001 are legal. Every other code, including 000, is illegal.
- All outputs are registered. The light value present before edge k is evaluated at edge k, and the result is visible immediately after edge k (one-cycle latency).
- Dwell counter: loads 1 when a new legal code is accepted. Increments while the same code is held. Saturates at all-ones.
- FSM states: SYNC, TRACK, FAULT.
- SYNC:
  - Illegal codes (000 from an uninitialised generator included) are ignored, with no error.
  - First legal code: phase=that code, dwell=1, go to TRACK, in_sync=1.
  - No dwell-min check on this first phase.
- TRACK, per edge:
  - same legal code: if dwell==MAX_DWELL -> dwell violation; else dwell++.
  - new legal code that is the correct successor: if dwell<MIN_DWELL -> dwell violation; else accept (phase updates, dwell=1).
  - red->green acceptance increments cycle_cnt, saturating.
  - new legal code that is not the successor (e.g. green->red) -> bad order.
  - illegal code -> illegal-code error.
  - Priority when several apply in the same cycle: illegal > bad order > dwell.
- On any error: go to FAULT; err=1; err_code=cause; in_sync=0. phase and cycle_cnt freeze at their pre-error values.
- FAULT: holds until rst or clr. Further errors do not overwrite err_code (first cause wins).
- clr=1 (rst=0), any state: err=0, err_code=00, in_sync=0, phase=00, dwell=0, FSM=SYNC. cycle_cnt is preserved; only rst zeroes it.
- With defaults (MIN=MAX=1) the generator's one-code-per-clock rotation is the only legal behaviour. Any repeated code is a dwell violation.
- Reset mid-sequence: the monitor restarts in SYNC and re-locks on the next legal code. No error results from the sequence being broken across the reset.

Test Plan:
- Reset, then light 000 for 3 cycles, then 010,001,100,010,001,100,010 (defaults) -> in_sync=1 from the first 010 sample, err stays 0, cycle_cnt=2, phase tracks 01,10,11,01...
- Locked, sequence 010 -> 100 (green to red) -> err=1, err_code=10, in_sync=0, phase frozen at 01. Further bad codes leave err_code=10.
- Locked, inject 110 -> err_code=01. Then assert clr one cycle with 010 following -> err=0, relocks, cycle_cnt unchanged.
- MIN_DWELL=2, MAX_DWELL=3: each code held 2 cycles -> no error. Yellow held 4 cycles -> err_code=11 on the 4th yellow sample. Green held 1 cycle after red (not the first phase) -> err_code=11.
- CNT_W=2, run 5 full legal rotations -> cycle_cnt saturates at 3, no error.
- Assert rst mid-rotation (after yellow), release and resume at red -> SYNC, then locks on red with err=0 and cycle_cnt restarting from 0.
